// File: rtl/instr_fetch_buffer_if.sv
// Fetch front-end bundle: instruction-memory request/response, execute redirect and decode output.
// master = fetch buffer side, slave = memory/execute/decode side.
interface instr_fetch_buffer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr;
    logic [31:0] instr_pc;
    logic        misalign_err;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, Instr, instr_pc, misalign_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, Instr, instr_pc, misalign_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Sequential instruction fetch with a DEPTH-entry in-order response FIFO and redirect flush/drain.
// Response to instr_valid is one cycle; issue throttles on outstanding+buffered, decode stalls via instr_ready.
module instr_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_fetch_buffer_if.master  bus
);
    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [31:0]    pc;
    logic [31:0]    rsp_pc;
    logic [31:0]    redirect_target;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  outstanding_nxt;
    logic [CW-1:0]  drop;
    logic [CW-1:0]  fifo_count;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [31:0]    fifo_dat [DEPTH];
    logic [31:0]    fifo_pc  [DEPTH];
    logic           misalign_q;
    logic           issue_ok;
    logic           req_fire;
    logic           push;
    logic           pop;
    logic           drop_rsp;

    assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
    assign issue_ok  = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W;
    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    // A redirect kills everything in its cycle: the request, the arriving response and the pop.
    assign push      = bus.imem_rsp_valid && (drop == '0) && !bus.redirect;
    assign drop_rsp  = bus.imem_rsp_valid && (drop != '0) && !bus.redirect;
    assign pop       = bus.instr_valid && bus.instr_ready && !bus.redirect;
    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.redirect) begin
            state_nxt = (outstanding_nxt != '0) ? DRAIN : FETCH;
        end else begin
            case (state)
                FETCH:   state_nxt = FETCH;
                DRAIN:   if (drop == '0) state_nxt = FETCH;
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_comb begin
        bus.imem_req_valid = 1'b0;
        bus.imem_addr      = pc;
        if (rst_n && (state == FETCH) && issue_ok && !bus.redirect) begin
            bus.imem_req_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q  <= bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
            outstanding <= outstanding_nxt;
            if (bus.redirect) begin
                pc     <= redirect_target;
                rsp_pc <= redirect_target;
                drop   <= outstanding_nxt;
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                if (push)     rsp_pc <= rsp_pc + 32'd4;
                if (drop_rsp) drop <= drop - CW'(1);
            end
        end
    end

    // Response FIFO; the head is read straight from registered storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_dat[i] <= '0;
                fifo_pc[i]  <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (bus.redirect) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_dat[wr_ptr] <= bus.imem_rsp_data;
                fifo_pc[wr_ptr]  <= rsp_pc;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    assign bus.instr_valid  = (fifo_count != '0);
    assign bus.Instr        = fifo_dat[rd_ptr];
    assign bus.instr_pc     = fifo_pc[rd_ptr];
    assign bus.misalign_err = misalign_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifo_count == DEPTH_C)));
    a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rsp_valid && (outstanding == '0)));
endmodule
